// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forward-select control for the 5-stage MIPS pipeline.
// Define HAZ_STALL_CNT_EN to add the stall_cnt counter port.
module hazard_ctrl #(
    parameter int REG_W = 5
`ifdef HAZ_STALL_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_D,
    input  logic [REG_W-1:0] rt_D,
    input  logic [1:0]       tuse_rs_D,
    input  logic [1:0]       tuse_rt_D,
    input  logic [REG_W-1:0] a3_D,
    input  logic [1:0]       tnew_D,
    input  logic [1:0]       res_D,
    output logic             stall,
    output logic [2:0]       F_RS_sel,
    output logic [2:0]       F_RT_sel,
    output logic [2:0]       F_ALUA_Esel,
    output logic [2:0]       F_ALUB_Esel,
    output logic [2:0]       F_WD_Msel
`ifdef HAZ_STALL_CNT_EN
    , output logic [CNT_W-1:0] stall_cnt
`endif
);
    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_PC8  = 2'd3;

    logic [REG_W-1:0] rs_E, rt_E, a3_E, rt_M, a3_M, a3_W;
    logic [1:0]       tnew_E, res_E, tnew_M, res_M, res_W;
    logic             rs_he, rs_hm, rs_hw, rt_he, rt_hm, rt_hw;
    logic             rse_hm, rse_hw, rte_hm, rte_hw, rtm_hw;

    function automatic logic hit(input logic [REG_W-1:0] r, a, input logic [1:0] res);
        return r != '0 && r == a && res != RES_NONE;
    endfunction

    function automatic logic [2:0] fwd(input logic [1:0] res, input logic [2:0] pc8, alu);
        return res == RES_PC8 ? pc8 : alu;
    endfunction

    assign rs_he  = hit(rs_D, a3_E, res_E);
    assign rs_hm  = hit(rs_D, a3_M, res_M);
    assign rs_hw  = hit(rs_D, a3_W, res_W);
    assign rt_he  = hit(rt_D, a3_E, res_E);
    assign rt_hm  = hit(rt_D, a3_M, res_M);
    assign rt_hw  = hit(rt_D, a3_W, res_W);
    assign rse_hm = hit(rs_E, a3_M, res_M);
    assign rse_hw = hit(rs_E, a3_W, res_W);
    assign rte_hm = hit(rt_E, a3_M, res_M);
    assign rte_hw = hit(rt_E, a3_W, res_W);
    assign rtm_hw = hit(rt_M, a3_W, res_W);

    // tuse = 3 can never be below a 2-bit tnew, so unused operands never stall
    always_comb begin
        stall = (rs_he && tuse_rs_D < tnew_E) || (rs_hm && tuse_rs_D < tnew_M) ||
                (rt_he && tuse_rt_D < tnew_E) || (rt_hm && tuse_rt_D < tnew_M);
        F_RS_sel = rs_he ? fwd(res_E, 3'b011, 3'b000) :
                   rs_hm ? (tnew_M == 2'd0 ? fwd(res_M, 3'b100, 3'b001) : 3'b000) :
                   rs_hw ? fwd(res_W, 3'b101, 3'b010) : 3'b000;
        F_RT_sel = rt_he ? fwd(res_E, 3'b011, 3'b000) :
                   rt_hm ? (tnew_M == 2'd0 ? fwd(res_M, 3'b100, 3'b001) : 3'b000) :
                   rt_hw ? fwd(res_W, 3'b101, 3'b010) : 3'b000;
        F_ALUA_Esel = rse_hm && tnew_M == 2'd0 ? fwd(res_M, 3'b100, 3'b001) :
                      rse_hw ? fwd(res_W, 3'b101, 3'b010) : 3'b000;
        F_ALUB_Esel = rte_hm && tnew_M == 2'd0 ? fwd(res_M, 3'b100, 3'b001) :
                      rte_hw ? fwd(res_W, 3'b101, 3'b010) : 3'b000;
        F_WD_Msel = rtm_hw ? fwd(res_W, 3'b101, 3'b010) : 3'b000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_E   <= '0;
            rt_E   <= '0;
            a3_E   <= '0;
            tnew_E <= '0;
            res_E  <= '0;
            rt_M   <= '0;
            a3_M   <= '0;
            tnew_M <= '0;
            res_M  <= '0;
            a3_W   <= '0;
            res_W  <= '0;
        end else begin
            a3_W   <= a3_M;
            res_W  <= res_M;
            rt_M   <= rt_E;
            a3_M   <= a3_E;
            tnew_M <= tnew_E == 2'd0 ? 2'd0 : tnew_E - 2'd1;
            res_M  <= res_E;
            rs_E   <= stall ? '0 : rs_D;
            rt_E   <= stall ? '0 : rt_D;
            a3_E   <= stall ? '0 : a3_D;
            tnew_E <= stall ? '0 : tnew_D;
            res_E  <= stall ? '0 : res_D;
        end
    end

`ifdef HAZ_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against an instruction-level pipeline model.
module tb_hazard_ctrl;
    typedef struct {
        logic [4:0] rs, rt, a3;
        logic [1:0] urs, urt, tnew, res;
    } ins_t;

    logic       clk = 0, reset = 1;
    logic [4:0] rs_D, rt_D, a3_D;
    logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D, res_D;
    logic       stall;
    logic [2:0] F_RS_sel, F_RT_sel, F_ALUA_Esel, F_ALUB_Esel, F_WD_Msel;
`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt;
    int unsigned cnt_m = 0;
`endif

    ins_t pipe[3];
    ins_t cur, nop, d;
    int   n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
        .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .a3_D(a3_D),
        .tnew_D(tnew_D), .res_D(res_D), .stall(stall),
        .F_RS_sel(F_RS_sel), .F_RT_sel(F_RT_sel), .F_ALUA_Esel(F_ALUA_Esel),
        .F_ALUB_Esel(F_ALUB_Esel), .F_WD_Msel(F_WD_Msel)
`ifdef HAZ_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    function automatic ins_t mk(logic [4:0] rs, logic [1:0] urs, logic [4:0] rt, logic [1:0] urt,
                                logic [4:0] a3, logic [1:0] tnew, logic [1:0] res);
        ins_t i;
        i.rs = rs; i.urs = urs; i.rt = rt; i.urt = urt; i.a3 = a3; i.tnew = tnew; i.res = res;
        return i;
    endfunction

    // pipe[0] = E, pipe[1] = M, pipe[2] = W; tnew held as the value in that stage
    function automatic bit hit(logic [4:0] r, int k);
        return r != 0 && pipe[k].a3 == r && pipe[k].res != 0;
    endfunction

    function automatic logic [2:0] pick(int k, logic [2:0] pc8, logic [2:0] other);
        return pipe[k].res == 2'd3 ? pc8 : other;
    endfunction

    function automatic logic [2:0] d_sel(logic [4:0] r);
        if (hit(r, 0)) return pick(0, 3'd3, 3'd0);
        if (hit(r, 1)) return pipe[1].tnew == 0 ? pick(1, 3'd4, 3'd1) : 3'd0;
        if (hit(r, 2)) return pick(2, 3'd5, 3'd2);
        return 3'd0;
    endfunction

    function automatic logic [2:0] e_sel(logic [4:0] r);
        if (hit(r, 1) && pipe[1].tnew == 0) return pick(1, 3'd4, 3'd1);
        if (hit(r, 2)) return pick(2, 3'd5, 3'd2);
        return 3'd0;
    endfunction

    function automatic bit need(logic [4:0] r, logic [1:0] u);
        for (int k = 0; k < 2; k++)
            if (hit(r, k) && u < pipe[k].tnew) return 1;
        return 0;
    endfunction

    function automatic bit stall_m();
        return need(cur.rs, cur.urs) || need(cur.rt, cur.urt);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) pipe[k] = nop;
`ifdef HAZ_STALL_CNT_EN
        cnt_m = 0;
`endif
    endtask

    task automatic drive(ins_t i);
        cur = i;
        rs_D = i.rs; rt_D = i.rt; tuse_rs_D = i.urs; tuse_rt_D = i.urt;
        a3_D = i.a3; tnew_D = i.tnew; res_D = i.res;
        #2;
        check("stall", 32'(stall), 32'(stall_m()));
        check("rs_sel", 32'(F_RS_sel), 32'(d_sel(i.rs)));
        check("rt_sel", 32'(F_RT_sel), 32'(d_sel(i.rt)));
        check("alua_sel", 32'(F_ALUA_Esel), 32'(e_sel(pipe[0].rs)));
        check("alub_sel", 32'(F_ALUB_Esel), 32'(e_sel(pipe[0].rt)));
        check("wd_sel", 32'(F_WD_Msel), 32'(hit(pipe[1].rt, 2) ? pick(2, 3'd5, 3'd2) : 3'd0));
`ifdef HAZ_STALL_CNT_EN
        check("stall_cnt", stall_cnt, cnt_m);
`endif
    endtask

    task automatic tick();
        bit s;
        @(posedge clk);
        #1;
        s = stall_m();
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[1].tnew = pipe[1].tnew == 0 ? 2'd0 : pipe[1].tnew - 2'd1;
        pipe[0] = s ? nop : cur;
`ifdef HAZ_STALL_CNT_EN
        if (s) cnt_m++;
`endif
    endtask

    task automatic flush();
        for (int k = 0; k < 3; k++) begin
            drive(nop);
            tick();
        end
    endtask

    initial begin
        nop = mk(0, 3, 0, 3, 0, 0, 0);
        clear_model();
        drive(nop);
        check("rst_stall", 32'(stall), 0);
        check("rst_sel", 32'({F_RS_sel, F_RT_sel, F_ALUA_Esel, F_ALUB_Esel, F_WD_Msel}), 0);
        reset = 0;
        tick();
        // add $1 then beq $1
        drive(mk(0, 3, 0, 3, 1, 1, 1)); tick();
        drive(mk(1, 0, 0, 3, 0, 0, 0));
        check("t1_stall", 32'(stall), 1);
        tick();
        drive(mk(1, 0, 0, 3, 0, 0, 0));
        check("t1_fwd", 32'(F_RS_sel), 1);
        check("t1_nostall", 32'(stall), 0);
        tick(); flush();
        // lw $2 then add rt=$2
        drive(mk(0, 3, 0, 3, 2, 2, 2)); tick();
        drive(mk(0, 3, 2, 1, 4, 1, 1));
        check("t2_stall", 32'(stall), 1);
        tick();
        drive(mk(0, 3, 2, 1, 4, 1, 1)); tick();
        drive(nop);
        check("t2_alub", 32'(F_ALUB_Esel), 2);
        tick(); flush();
        // jal then jr $31
        drive(mk(0, 3, 0, 3, 31, 0, 3)); tick();
        drive(mk(31, 0, 0, 3, 0, 0, 0));
        check("t3_stall", 32'(stall), 0);
        check("t3_rs", 32'(F_RS_sel), 3);
        tick();
        drive(nop);
        check("t3_alua", 32'(F_ALUA_Esel), 4);
        tick(); flush();
        // lw $3 then sw rt=$3
        drive(mk(0, 3, 0, 3, 3, 2, 2)); tick();
        drive(mk(0, 3, 3, 2, 0, 0, 0));
        check("t4_stall", 32'(stall), 0);
        tick();
        drive(nop);
        check("t4_alub", 32'(F_ALUB_Esel), 0);
        tick();
        drive(nop);
        check("t4_wd", 32'(F_WD_Msel), 2);
        tick(); flush();
        // writes to $0 never hazard
        drive(mk(0, 3, 0, 3, 0, 1, 1)); tick();
        drive(mk(0, 0, 0, 0, 0, 0, 0));
        check("t5_stall", 32'(stall), 0);
        check("t5_sel", 32'({F_RS_sel, F_RT_sel, F_ALUA_Esel, F_ALUB_Esel, F_WD_Msel}), 0);
        tick(); flush();
        // reset asserted during a stall
        drive(mk(0, 3, 0, 3, 1, 1, 1)); tick();
        drive(mk(1, 0, 0, 3, 0, 0, 0));
        check("t6_pre", 32'(stall), 1);
        reset = 1;
        #1;
        check("t6_stall", 32'(stall), 0);
        check("t6_sel", 32'({F_RS_sel, F_RT_sel, F_ALUA_Esel, F_ALUB_Esel, F_WD_Msel}), 0);
`ifdef HAZ_STALL_CNT_EN
        check("t6_cnt", stall_cnt, 0);
`endif
        reset = 0;
        clear_model();
        tick();
        for (int n = 0; n < 400; n++) begin
            d = mk(5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                   2'($urandom_range(0, 3)));
            drive(d);
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
